// File: rtl/pulse_rate_calc.sv
// Beat-to-beat rate meter: times the inter-beat interval in ticks, converts it to BPM
// with a 16-cycle restoring divider and smooths the result over the last four beats.
module pulse_rate_calc #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int MIN_IBI_MS = 300,
  parameter int MAX_IBI_MS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beat_in,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       bpm_update,
  output logic       no_signal
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [11:0] MAX_IBI = 12'(MAX_IBI_MS);
  localparam logic [11:0] MIN_IBI = 12'(MIN_IBI_MS);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, AVERAGE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pre;
  logic            tick;
  logic [11:0]     ibi_cnt, ibi;
  logic [15:0]     dvd;
  logic [11:0]     rem;
  logic [7:0]      quo;
  logic [3:0]      div_cnt;
  logic            first_flag;
  logic [3:0][7:0] hist, hist_nxt;
  logic            start, accept, timeout;
  logic [12:0]     trial;
  logic            ge;
  logic [11:0]     diff;
  logic [9:0]      sum, sum_r;
  logic [7:0]      avg;

  assign tick = (pre == PW'(DIV - 1));

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE:
        if (beat_in) begin
          start     = 1'b1;
          state_nxt = MEASURE;
        end
      MEASURE:
        if (ibi_cnt == MAX_IBI) begin
          timeout = 1'b1;
          // a beat landing on the timeout cycle restarts the train at once
          if (beat_in) begin
            start     = 1'b1;
            state_nxt = MEASURE;
          end else begin
            state_nxt = IDLE;
          end
        end else if (beat_in && ibi_cnt >= MIN_IBI) begin
          accept    = 1'b1;
          state_nxt = DIVIDE;
        end
      DIVIDE:  if (div_cnt == 4'd15) state_nxt = AVERAGE;
      AVERAGE: state_nxt = MEASURE;
      default: state_nxt = IDLE;
    endcase
  end

  // restoring step: remainder stays below ibi, so 12 bits plus the incoming bit suffice
  always_comb begin
    trial = {rem, dvd[15]};
    ge    = (trial >= {1'b0, ibi});
    diff  = trial[11:0] - ibi;
  end

  always_comb begin
    hist_nxt = first_flag ? {4{quo}} : {hist[2:0], quo};
    sum      = 10'(hist_nxt[0]) + 10'(hist_nxt[1]) + 10'(hist_nxt[2]) + 10'(hist_nxt[3]);
    sum_r    = sum + 10'd2;
    avg      = sum_r[9:2];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pre        <= '0;
      ibi_cnt    <= '0;
      ibi        <= '0;
      dvd        <= '0;
      rem        <= '0;
      quo        <= '0;
      div_cnt    <= '0;
      hist       <= '0;
      first_flag <= 1'b1;
      bpm        <= '0;
      bpm_valid  <= 1'b0;
      bpm_update <= 1'b0;
      no_signal  <= 1'b1;
    end else begin
      state      <= state_nxt;
      bpm_update <= 1'b0;
      pre        <= tick ? '0 : pre + PW'(1);

      if (start || accept)             ibi_cnt <= '0;
      else if (tick && ibi_cnt != MAX_IBI) ibi_cnt <= ibi_cnt + 12'd1;

      if (start || timeout) first_flag <= 1'b1;

      if (timeout) begin
        bpm       <= '0;
        bpm_valid <= 1'b0;
        no_signal <= 1'b1;
      end

      if (accept) begin
        ibi     <= ibi_cnt;
        dvd     <= 16'd60000;
        rem     <= '0;
        quo     <= '0;
        div_cnt <= '0;
      end

      if (state == DIVIDE) begin
        rem     <= ge ? diff : trial[11:0];
        quo     <= {quo[6:0], ge};
        dvd     <= {dvd[14:0], 1'b0};
        div_cnt <= div_cnt + 4'd1;
      end

      if (state == AVERAGE) begin
        hist       <= hist_nxt;
        first_flag <= 1'b0;
        bpm        <= avg;
        bpm_valid  <= 1'b1;
        no_signal  <= 1'b0;
        bpm_update <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_rate_calc.sv
// Randomized + directed bench for pulse_rate_calc with an event-level reference model
// (tick every clk) checked every cycle, plus literal checks of known BPM results.
module tb_pulse_rate_calc;

  localparam int MIN = 300;
  localparam int MAX = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       beat_in = 1'b0;
  logic [7:0] bpm;
  logic       bpm_valid, bpm_update, no_signal;

  pulse_rate_calc #(.CLK_HZ(1000), .TICK_HZ(1000), .MIN_IBI_MS(MIN), .MAX_IBI_MS(MAX)) dut (
    .clk(clk), .rst(rst), .beat_in(beat_in),
    .bpm(bpm), .bpm_valid(bpm_valid), .bpm_update(bpm_update), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int cyc = 0, upd_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // reference model: mode 0 idle, 1 measuring, 2 busy until avg_at
  int m_mode, m_ibi, m_q, avg_at, m_sum;
  bit m_first, m_init = 0, m_clr;
  int m_hist[4];
  int e_bpm, e_valid, e_upd, e_nosig;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_mode = 0; m_ibi = 0; m_first = 1; avg_at = -1;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
      e_bpm = 0; e_valid = 0; e_upd = 0; e_nosig = 1;
      m_init = 1;
    end else if (m_init) begin
      m_clr = 0; e_upd = 0;
      case (m_mode)
        0: if (beat_in) begin m_clr = 1; m_mode = 1; end
        1: if (m_ibi == MAX) begin
             e_bpm = 0; e_valid = 0; e_nosig = 1; m_first = 1;
             if (beat_in) m_clr = 1; else m_mode = 0;
           end else if (beat_in && m_ibi >= MIN) begin
             m_q = 60000 / m_ibi; m_clr = 1; m_mode = 2; avg_at = cyc + 17;
           end
        default: if (cyc == avg_at) begin
             if (m_first) for (int i = 0; i < 4; i++) m_hist[i] = m_q;
             else begin
               for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
               m_hist[0] = m_q;
             end
             m_first = 0;
             m_sum = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
             e_bpm = (m_sum + 2) / 4; e_valid = 1; e_nosig = 0; e_upd = 1;
             m_mode = 1;
           end
      endcase
      m_ibi = m_clr ? 0 : ((m_ibi < MAX) ? m_ibi + 1 : MAX);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("bpm", int'(bpm), e_bpm);
      chk("bpm_valid", int'(bpm_valid), e_valid);
      chk("bpm_update", int'(bpm_update), e_upd);
      chk("no_signal", int'(no_signal), e_nosig);
      if (bpm_update) upd_cnt++;
    end
  end

  int last_b = 0;

  task automatic tick_n(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic beat_at(input int n);
    int target;
    target = last_b + n;
    beat_in = 1'b0;
    while (cyc < target) tick_n(1);
    beat_in = 1'b1;
    last_b = cyc;
    tick_n(1);
    beat_in = 1'b0;
  endtask

  task automatic settle_chk(input string name, input int exp_bpm);
    while (cyc < last_b + 20) tick_n(1);
    chk(name, int'(bpm), exp_bpm);
  endtask

  initial begin
    int lat, u0, r, gap;
    // 1: reset held with beats toggling
    for (int i = 0; i < 3; i++) begin
      beat_in = i[0];
      tick_n(1);
      chk("rst_bpm", int'(bpm), 0);
      chk("rst_valid", int'(bpm_valid), 0);
      chk("rst_nosig", int'(no_signal), 1);
    end
    beat_in = 1'b0;
    rst = 1'b1;
    last_b = cyc;

    // 2: first beat silent, second 1000 later gives 60 with 18-cycle latency
    u0 = upd_cnt;
    beat_at(5);
    beat_at(1000);
    chk("first_beat_no_update", upd_cnt - u0, 0);
    while (!bpm_update && cyc < last_b + 40) tick_n(1);
    lat = cyc - last_b;
    chk("update_latency", lat, 18);
    chk("bpm_60", int'(bpm), 60);
    chk("valid_60", int'(bpm_valid), 1);
    chk("nosig_60", int'(no_signal), 0);

    // 3: 750 ms intervals
    beat_at(750);
    settle_chk("bpm_65", 65);
    repeat (3) beat_at(750);
    settle_chk("bpm_80", 80);

    // 4: refractory rejection then 800 ms beat
    repeat (4) beat_at(1000);
    settle_chk("bpm_steady_60", 60);
    u0 = upd_cnt;
    beat_at(200);
    tick_n(30);
    chk("refractory_no_update", upd_cnt - u0, 0);
    beat_at(600);
    settle_chk("bpm_64", 64);

    // 5: timeout and restart with preloaded history
    while (cyc < last_b + 2100) tick_n(1);
    chk("to_bpm", int'(bpm), 0);
    chk("to_valid", int'(bpm_valid), 0);
    chk("to_nosig", int'(no_signal), 1);
    beat_at(100);
    tick_n(30);
    chk("after_to_still_invalid", int'(bpm_valid), 0);
    beat_at(1000);
    settle_chk("bpm_restart_60", 60);

    // 6: reset in the middle of the divide
    beat_at(1000);
    while (cyc < last_b + 5) tick_n(1);
    u0 = upd_cnt;
    rst = 1'b0; tick_n(1); rst = 1'b1;
    tick_n(30);
    chk("abort_no_update", upd_cnt - u0, 0);
    chk("abort_bpm", int'(bpm), 0);
    chk("abort_nosig", int'(no_signal), 1);
    last_b = cyc;
    beat_at(50);
    beat_at(750);
    settle_chk("bpm_post_reset_80", 80);

    // randomized beat trains, timeouts and resets
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) gap = $urandom_range(1, 25);
      else if (r == 1) gap = $urandom_range(1995, 2100);
      else if (r == 2) gap = $urandom_range(280, 320);
      else gap = $urandom_range(250, 1300);
      if (r == 3 && k[0]) begin
        rst = 1'b0; tick_n($urandom_range(1, 3)); rst = 1'b1;
      end
      beat_at(gap);
    end
    tick_n(2200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
